// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter and the data memory it fronts.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie, the port that did not win last time is granted.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lastGnt,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = (lastGnt == PORT_LDR);
            gnt1 = (lastGnt == PORT_CPU);
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the loader (port 1),
// with round-robin fairness, bounded loader bursts and tagged one-cycle read return.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = dmem_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W   = dmem_arbiter_pkg::DATA_W,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              cpu_stall,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    import dmem_arbiter_pkg::*;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

    logic       lastGnt;
    logic       prevGnt1;
    logic [3:0] burstCnt;
    logic       rdPend;
    logic       rdId;

    logic rrGnt0, rrGnt1;
    logic holdP1, yieldP0;
    logic selGnt0, selGnt1;
    logic selPort, selWe, anyGnt;

    rr_pick2 uPick (
        .req0    (req0),
        .req1    (req1),
        .lastGnt (lastGnt),
        .gnt0    (rrGnt0),
        .gnt1    (rrGnt1)
    );

    // Burst hold outranks the yield; both outrank plain round-robin.
    always_comb begin
        holdP1  = prevGnt1 & req1 & lock1 & (burstCnt < LOCK_LIM);
        yieldP0 = (burstCnt == LOCK_LIM) & req0;
        selGnt0 = rrGnt0;
        selGnt1 = rrGnt1;
        if (holdP1) begin
            selGnt0 = 1'b0;
            selGnt1 = 1'b1;
        end else if (yieldP0) begin
            selGnt0 = 1'b1;
            selGnt1 = 1'b0;
        end
    end

    always_comb begin
        gnt0      = selGnt0 & reset;
        gnt1      = selGnt1 & reset;
        anyGnt    = gnt0 | gnt1;
        selPort   = gnt1 ? PORT_LDR : PORT_CPU;
        selWe     = gnt1 ? we1 : we0;
        mem_addr  = gnt1 ? addr1 : addr0;
        mem_wdata = gnt1 ? wdata1 : wdata0;
        mem_we    = anyGnt & selWe;
        mem_re    = anyGnt & ~selWe;
        cpu_stall = req0 & ~gnt0 & reset;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastGnt  <= PORT_LDR;
            prevGnt1 <= 1'b0;
            burstCnt <= '0;
            rdPend   <= 1'b0;
            rdId     <= PORT_CPU;
        end else begin
            if (anyGnt) begin
                lastGnt <= selPort;
            end
            prevGnt1 <= gnt1;
            if (gnt1 && lock1) begin
                if (burstCnt != LOCK_LIM) begin
                    burstCnt <= burstCnt + 4'd1;
                end
            end else begin
                burstCnt <= '0;
            end
            rdPend <= mem_re;
            rdId   <= selPort;
        end
    end

    assign rvalid0 = rdPend & (rdId == PORT_CPU);
    assign rvalid1 = rdPend & (rdId == PORT_LDR);
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a rule-level reference model predicts grants and read returns.
module tb_dmem_arbiter;

    localparam int LOCK_MAX = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, cpu_stall, mem_we, mem_re;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .cpu_stall(cpu_stall),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    // Single-port memory behind the arbiter, preloaded with addr ^ 0x4A.
    logic [7:0] hmem [256];
    logic       memReady = 1'b0;
    always @(posedge clock) begin
        if (!memReady) begin
            for (int i = 0; i < 256; i++) hmem[i] <= 8'(i) ^ 8'h4A;
            memReady <= 1'b1;
        end else begin
            if (mem_we) hmem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= hmem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [4:0] flags;
        logic       chkAddr;
        logic [7:0] addr;
        logic       chkData;
        logic [7:0] wdata;
    } gexp_t;

    typedef struct {
        int         due;
        int         port;
        logic [7:0] data;
    } rexp_t;

    gexp_t gntQ[$];
    rexp_t rdQ[$];
    int    gAt[int];
    int    total = 0;
    int    bad = 0;

    logic [7:0] refMem [256];
    int         mLast = 1;
    int         mRun = 0;
    bit         mPrevP1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: apply inputs, predict the arbiter's response and queue it for the monitor.
    task automatic drive(input logic rst, input logic r0, input logic w0, input logic [7:0] a0,
                         input logic [7:0] d0, input logic r1, input logic w1, input logic [7:0] a1,
                         input logic [7:0] d1, input logic l1, output int g);
        gexp_t      ge;
        rexp_t      re;
        logic       wsel, doWe, doRe;
        logic [7:0] a, d;
        @(posedge clock);
        #1;
        reset = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        g = -1;
        if (!rst) begin
            mLast = 1; mRun = 0; mPrevP1 = 1'b0;
            rdQ.delete();
        end else begin
            if (mPrevP1 && r1 && l1 && mRun < LOCK_MAX) g = 1;
            else if (mRun == LOCK_MAX && r0)             g = 0;
            else if (r0 && r1)                           g = 1 - mLast;
            else if (r0)                                 g = 0;
            else if (r1)                                 g = 1;
            if (g >= 0) mLast = g;
            mRun    = (g == 1 && l1) ? ((mRun < LOCK_MAX) ? mRun + 1 : LOCK_MAX) : 0;
            mPrevP1 = (g == 1);
        end
        wsel = (g == 1) ? w1 : w0;
        a    = (g == 1) ? a1 : a0;
        d    = (g == 1) ? d1 : d0;
        doWe = (g >= 0) && wsel;
        doRe = (g >= 0) && !wsel;
        ge.due     = cyc;
        ge.flags   = {g == 0, g == 1, doWe, doRe, rst & r0 & (g != 0)};
        ge.chkAddr = (g >= 0);
        ge.addr    = a;
        ge.chkData = doWe;
        ge.wdata   = d;
        gntQ.push_back(ge);
        if (doWe) refMem[a] = d;
        if (doRe) begin
            re.due  = cyc + 1;
            re.port = g;
            re.data = refMem[a];
            rdQ.push_back(re);
        end
    endtask

    task automatic idle(input logic rst);
        int g;
        drive(rst, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
    endtask

    gexp_t      mg;
    rexp_t      mr;
    logic [1:0] expV;
    always @(negedge clock) begin
        if (gntQ.size() > 0 && gntQ[0].due == cyc) begin
            mg = gntQ.pop_front();
            check("grant{g0,g1,we,re,stall}", {27'b0, gnt0, gnt1, mem_we, mem_re, cpu_stall}, {27'b0, mg.flags});
            if (mg.chkAddr) check("mem_addr", {24'b0, mem_addr}, {24'b0, mg.addr});
            if (mg.chkData) check("mem_wdata", {24'b0, mem_wdata}, {24'b0, mg.wdata});
        end
        expV = 2'b00;
        if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
            mr   = rdQ.pop_front();
            expV = (mr.port == 1) ? 2'b10 : 2'b01;
        end
        check("rvalid{1,0}", {30'b0, rvalid1, rvalid0}, {30'b0, expV});
        if (expV == 2'b01) check("rdata0", {24'b0, rdata0}, {24'b0, mr.data});
        if (expV == 2'b10) check("rdata1", {24'b0, rdata1}, {24'b0, mr.data});
        gAt[cyc] = gnt1 ? 1 : (gnt0 ? 0 : 2);
    end

    initial begin
        int g, c0, k0, k1, i;
        int pat3 [10];
        logic p0v, p0w, p1v, p1w, l1, rst;
        logic [7:0] p0a, p0d, p1a, p1d;

        for (int j = 0; j < 256; j++) refMem[j] = 8'(j) ^ 8'h4A;

        // Reset held with a CPU request pending, then release into the read of 0x10.
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
        idle(1'b1);

        // Both ports read continuously without lock: strict alternation from port 0.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h60, 8'h99, 1'b0, g);
        k0 = 0; k1 = 0; c0 = 0;
        for (int t = 0; t < 6; t++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h10 + 8'(k0), 8'h00, 1'b1, 1'b0, 8'h50 + 8'(k1), 8'h00, 1'b0, g);
            if (t == 0) c0 = cyc;
            if (g == 0) k0++;
            if (g == 1) k1++;
        end
        idle(1'b1);
        for (int t = 0; t < 6; t++) check("alternate", gAt[c0 + t], t % 2);

        // Locked loader burst against a CPU that keeps requesting.
        drive(1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
        pat3 = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        i = 0;
        for (int t = 0; t < 10; t++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h30, 8'h00, (i < 8), 1'b1, 8'h20 + 8'(i), 8'(i), 1'b1, g);
            if (t == 0) c0 = cyc;
            if (g == 1) i++;
        end
        idle(1'b1);
        for (int t = 0; t < 10; t++) check("burst_pattern", gAt[c0 + t], pat3[t]);
        for (int j = 0; j < 8; j++) check("burst_mem", {24'b0, hmem[8'h20 + 8'(j)]}, j);

        // Locked burst with no competitor keeps going past the limit.
        for (int t = 0; t < 8; t++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h70 + 8'(t), 8'(t + 1), 1'b1, g);
            if (t == 0) c0 = cyc;
        end
        idle(1'b1);
        for (int t = 0; t < 8; t++) check("solo_burst", gAt[c0 + t], 1);

        // Reset lands between a granted read and its return edge.
        drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
        @(negedge clock);
        #2;
        reset = 1'b0;
        rdQ.delete();
        mLast = 1; mRun = 0; mPrevP1 = 1'b0;
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // CPU write, then loader reads it back.
        drive(1'b1, 1'b1, 1'b1, 8'h40, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, g);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, g);
        idle(1'b1);
        idle(1'b1);

        // Random traffic with sticky requests, occasional drops, lock toggling and resets.
        p0v = 1'b0; p1v = 1'b0; l1 = 1'b0;
        p0w = 1'b0; p1w = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        for (int t = 0; t < 600; t++) begin
            if (!p0v) begin
                if ($urandom_range(0, 9) < 6) begin
                    p0v = 1'b1; p0w = 1'($urandom_range(0, 1));
                    p0a = 8'h80 | 8'($urandom_range(0, 15)); p0d = 8'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) p0v = 1'b0;
            if (!p1v) begin
                if ($urandom_range(0, 9) < 6) begin
                    p1v = 1'b1; p1w = 1'($urandom_range(0, 1));
                    p1a = 8'h80 | 8'($urandom_range(0, 15)); p1d = 8'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) p1v = 1'b0;
            if ($urandom_range(0, 9) == 0) l1 = ~l1;
            rst = ($urandom_range(0, 199) != 0);
            drive(rst, p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d, l1, g);
            if (g == 0) p0v = 1'b0;
            if (g == 1) p1v = 1'b0;
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("reads_drained", rdQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
